poly_voice_mixer: RTL and testbench

Parametrised N-voice allocator and mixer, replacing the fixed three-player note routing and hard-wired three-way sum in the music player. Accepts one note/duration request at a time from the song reader and assigns it to a free note player, or steals one when all are busy. On each sample strobe it snapshots all N voice samples, accumulates them sequentially with attenuation and per-voice mute, saturates, and presents one mixed sample to the codec conditioner.

---
 rtl/poly_voice_mixer.sv | 180 ++++++++++++++++++
 tb/tb_poly_voice_mixer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/poly_voice_mixer.sv
// poly_voice_mixer: N-voice note allocator with optional round-robin voice
// stealing, plus a sequential attenuating/saturating sample mixer.
module poly_voice_mixer #(
  parameter int NUM_VOICES   = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int NOTE_WIDTH   = 6,
  parameter int SHIFT        = 2,
  parameter int STEAL_EN     = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               note_valid,
  input  logic [NOTE_WIDTH-1:0]              note_in,
  input  logic [NOTE_WIDTH-1:0]              duration_in,
  input  logic [NUM_VOICES-1:0]              voice_done,
  input  logic [NUM_VOICES-1:0]              voice_mute,
  output logic [NUM_VOICES-1:0]              load_voice,
  output logic [NUM_VOICES*NOTE_WIDTH-1:0]   note_out,
  output logic [NUM_VOICES*NOTE_WIDTH-1:0]   duration_out,
  output logic [NUM_VOICES-1:0]              busy,
  output logic                               note_dropped,
  output logic                               voice_stolen,
  input  logic                               mix_start,
  input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] samples_in,
  output logic [SAMPLE_WIDTH-1:0]            mix_out,
  output logic                               mix_valid,
  output logic                               clip,
  output logic                               mix_overrun
);

  localparam int N  = NUM_VOICES;
  localparam int W  = SAMPLE_WIDTH;
  localparam int NW = NOTE_WIDTH;
  localparam int KW = $clog2(N);
  // One guard bit beyond clog2(N) so the running sum of N full-scale
  // samples can never wrap before saturation.
  localparam int AW = W + KW + 1;

  localparam logic signed [AW-1:0] MAXV = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  // ---------------------------------------------------------------- alloc
  logic [N-1:0]          busy_q, busy_d, load_q, tgt_oh;
  logic [N-1:0][NW-1:0]  note_q, dur_q;
  logic [KW-1:0]         steal_ptr_q, free_idx, tgt;
  logic                  any_free, do_load, do_steal, do_drop;
  logic                  dropped_q, stolen_q;

  // Lowest-index idle voice; scanning downward leaves the lowest one last.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        any_free = 1'b1;
        free_idx = KW'(i);
      end
    end
  end

  // Choose the target voice and the busy next-state; a load on the same
  // voice as a done pulse wins because it is OR-ed in after the clear.
  always_comb begin
    do_load  = note_valid & (any_free | (STEAL_EN != 0));
    do_steal = note_valid & ~any_free & (STEAL_EN != 0);
    do_drop  = note_valid & ~any_free & (STEAL_EN == 0);
    tgt      = any_free ? free_idx : steal_ptr_q;
    tgt_oh   = {{(N-1){1'b0}}, 1'b1} << tgt;
    busy_d   = (busy_q & ~voice_done) | (do_load ? tgt_oh : '0);
  end

  // Allocation state: busy flags, held note/duration, steal pointer, pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= '0;
      load_q      <= '0;
      note_q      <= '0;
      dur_q       <= '0;
      steal_ptr_q <= '0;
      dropped_q   <= 1'b0;
      stolen_q    <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      load_q    <= do_load ? tgt_oh : '0;
      dropped_q <= do_drop;
      stolen_q  <= do_steal;
      if (do_load) begin
        note_q[tgt] <= note_in;
        dur_q[tgt]  <= duration_in;
      end
      if (do_steal)
        steal_ptr_q <= (steal_ptr_q == KW'(N - 1)) ? '0 : steal_ptr_q + 1'b1;
    end
  end

  assign load_voice   = load_q;
  assign busy         = busy_q;
  assign note_out     = note_q;
  assign duration_out = dur_q;
  assign note_dropped = dropped_q;
  assign voice_stolen = stolen_q;

  // ---------------------------------------------------------------- mixer
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_SAT} state_t;

  state_t                state_q;
  logic [N-1:0][W-1:0]   snap_q;
  logic [KW-1:0]         k_q;
  logic signed [AW-1:0]  acc_q, acc_d, term;
  logic [AW-1:0]         term_ext;
  logic [W-1:0]          sat_d, mix_q;
  logic                  clip_d, clip_q, valid_q, overrun_q;

  // Sign-extend the current voice, attenuate, and add unless muted.
  always_comb begin
    term_ext = {{(AW-W){snap_q[k_q][W-1]}}, snap_q[k_q]};
    term     = $signed(term_ext) >>> SHIFT;
    acc_d    = voice_mute[k_q] ? acc_q : acc_q + term;
  end

  // Clamp the full-width sum into the output sample range.
  always_comb begin
    sat_d  = acc_q[W-1:0];
    clip_d = 1'b0;
    if (acc_q > MAXV) begin
      sat_d  = MAXV[W-1:0];
      clip_d = 1'b1;
    end else if (acc_q < MINV) begin
      sat_d  = MINV[W-1:0];
      clip_d = 1'b1;
    end
  end

  // Mixer FSM: snapshot, accumulate one voice per cycle, then saturate.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      snap_q    <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      mix_q     <= '0;
      clip_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mix_start) begin
            snap_q  <= samples_in;
            acc_q   <= '0;
            k_q     <= '0;
            state_q <= S_ACC;
          end
        end
        S_ACC: begin
          overrun_q <= mix_start;
          acc_q     <= acc_d;
          if (k_q == KW'(N - 1)) state_q <= S_SAT;
          else                   k_q     <= k_q + 1'b1;
        end
        S_SAT: begin
          overrun_q <= mix_start;
          mix_q     <= sat_d;
          clip_q    <= clip_d;
          valid_q   <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mix_out     = mix_q;
  assign clip        = clip_q;
  assign mix_valid   = valid_q;
  assign mix_overrun = overrun_q;

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Directed bench for poly_voice_mixer. Two instances share all inputs:
// u0 drops when full with SHIFT=2, u1 steals with SHIFT=0.
module tb_poly_voice_mixer;
  logic        clk = 1'b0;
  logic        reset, note_valid, mix_start;
  logic [5:0]  note_in, duration_in;
  logic [3:0]  voice_done, voice_mute;
  logic [63:0] samples_in;

  logic [3:0]  a_load_voice, a_busy, b_load_voice, b_busy;
  logic [23:0] a_note_out, a_duration_out, b_note_out, b_duration_out;
  logic        a_note_dropped, a_voice_stolen, b_note_dropped, b_voice_stolen;
  logic [15:0] a_mix_out, b_mix_out;
  logic        a_mix_valid, a_clip, a_mix_overrun, b_mix_valid, b_clip, b_mix_overrun;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  poly_voice_mixer #(.NUM_VOICES(4), .SAMPLE_WIDTH(16), .NOTE_WIDTH(6), .SHIFT(2), .STEAL_EN(0)) u0 (
    .clk(clk), .reset(reset), .note_valid(note_valid), .note_in(note_in), .duration_in(duration_in),
    .voice_done(voice_done), .voice_mute(voice_mute), .load_voice(a_load_voice), .note_out(a_note_out),
    .duration_out(a_duration_out), .busy(a_busy), .note_dropped(a_note_dropped), .voice_stolen(a_voice_stolen),
    .mix_start(mix_start), .samples_in(samples_in), .mix_out(a_mix_out), .mix_valid(a_mix_valid),
    .clip(a_clip), .mix_overrun(a_mix_overrun));

  poly_voice_mixer #(.NUM_VOICES(4), .SAMPLE_WIDTH(16), .NOTE_WIDTH(6), .SHIFT(0), .STEAL_EN(1)) u1 (
    .clk(clk), .reset(reset), .note_valid(note_valid), .note_in(note_in), .duration_in(duration_in),
    .voice_done(voice_done), .voice_mute(voice_mute), .load_voice(b_load_voice), .note_out(b_note_out),
    .duration_out(b_duration_out), .busy(b_busy), .note_dropped(b_note_dropped), .voice_stolen(b_voice_stolen),
    .mix_start(mix_start), .samples_in(samples_in), .mix_out(b_mix_out), .mix_valid(b_mix_valid),
    .clip(b_clip), .mix_overrun(b_mix_overrun));

  localparam logic [63:0] SAMP_A = {16'h0000, 16'hF800, 16'h2000, 16'h1000};

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Stimulus only: start a mix and wait (bounded) for u0's mix_valid.
  task automatic do_mix(input logic [63:0] s, input logic [3:0] m, output int lat);
    samples_in = s; voice_mute = m; mix_start = 1'b1;
    tick; mix_start = 1'b0; lat = 1;
    while (!a_mix_valid && lat < 12) begin tick; lat++; end
  endtask

  task automatic test_reset;
    reset = 1'b1; tick; tick;
    n_cmp++; if (a_busy !== 4'b0000) begin n_bad++; $display("FAIL reset_busy: got %b want 0000", a_busy); end
    n_cmp++; if (a_load_voice !== 4'b0000) begin n_bad++; $display("FAIL reset_load: got %b want 0000", a_load_voice); end
    n_cmp++; if (a_note_out !== 24'h0) begin n_bad++; $display("FAIL reset_note: got %h want 0", a_note_out); end
    n_cmp++; if (a_mix_out !== 16'h0 || a_mix_valid !== 1'b0 || a_clip !== 1'b0) begin n_bad++; $display("FAIL reset_mix: got %h/%b/%b want 0/0/0", a_mix_out, a_mix_valid, a_clip); end
    n_cmp++; if (b_busy !== 4'b0000 || b_voice_stolen !== 1'b0) begin n_bad++; $display("FAIL reset_b: got %b/%b want 0000/0", b_busy, b_voice_stolen); end
    reset = 1'b0;
  endtask

  task automatic test_alloc;
    logic [3:0] exp;
    for (int i = 0; i < 3; i++) begin
      note_valid = 1'b1; note_in = 6'(10 * (i + 1)); duration_in = 6'd4;
      tick; note_valid = 1'b0;
      exp = 4'(1 << i);
      n_cmp++; if (a_load_voice !== exp) begin n_bad++; $display("FAIL alloc_load%0d: got %b want %b", i, a_load_voice, exp); end
      tick;
    end
    n_cmp++; if (a_load_voice !== 4'b0000) begin n_bad++; $display("FAIL alloc_pulse: got %b want 0000", a_load_voice); end
    n_cmp++; if (a_busy !== 4'b0111) begin n_bad++; $display("FAIL alloc_busy: got %b want 0111", a_busy); end
    n_cmp++; if (a_note_out[12 +: 6] !== 6'd30) begin n_bad++; $display("FAIL alloc_note2: got %0d want 30", a_note_out[12 +: 6]); end
    n_cmp++; if (a_duration_out[12 +: 6] !== 6'd4) begin n_bad++; $display("FAIL alloc_dur2: got %0d want 4", a_duration_out[12 +: 6]); end
  endtask

  task automatic test_drop;
    note_valid = 1'b1; note_in = 6'd35; tick;
    n_cmp++; if (a_load_voice !== 4'b1000) begin n_bad++; $display("FAIL drop_fill: got %b want 1000", a_load_voice); end
    note_in = 6'd40; tick; note_valid = 1'b0;
    n_cmp++; if (a_note_dropped !== 1'b1 || a_load_voice !== 4'b0000) begin n_bad++; $display("FAIL drop_pulse: got %b/%b want 1/0000", a_note_dropped, a_load_voice); end
    n_cmp++; if (a_busy !== 4'b1111 || a_note_out[0 +: 6] !== 6'd10) begin n_bad++; $display("FAIL drop_state: got %b/%0d want 1111/10", a_busy, a_note_out[0 +: 6]); end
    n_cmp++; if (b_voice_stolen !== 1'b1 || b_load_voice !== 4'b0001) begin n_bad++; $display("FAIL steal_first: got %b/%b want 1/0001", b_voice_stolen, b_load_voice); end
    voice_done = 4'b0010; tick; voice_done = 4'b0000;
    n_cmp++; if (a_busy !== 4'b1101 || a_note_out[6 +: 6] !== 6'd20) begin n_bad++; $display("FAIL done_clear: got %b/%0d want 1101/20", a_busy, a_note_out[6 +: 6]); end
    note_valid = 1'b1; note_in = 6'd41; tick; note_valid = 1'b0;
    n_cmp++; if (a_load_voice !== 4'b0010 || a_note_dropped !== 1'b0) begin n_bad++; $display("FAIL reload: got %b/%b want 0010/0", a_load_voice, a_note_dropped); end
    n_cmp++; if (a_note_out[6 +: 6] !== 6'd41 || a_busy !== 4'b1111) begin n_bad++; $display("FAIL reload_note: got %0d/%b want 41/1111", a_note_out[6 +: 6], a_busy); end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp;
    reset = 1'b1; tick; reset = 1'b0;
    note_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      note_in = 6'(i + 1); tick; exp = 4'(1 << i);
      n_cmp++; if (b_load_voice !== exp || b_voice_stolen !== 1'b0) begin n_bad++; $display("FAIL b2b_fill%0d: got %b/%b want %b/0", i, b_load_voice, b_voice_stolen, exp); end
    end
    for (int i = 0; i < 5; i++) begin
      note_in = 6'(50 + i); tick; exp = 4'(1 << (i % 4));
      n_cmp++; if (b_load_voice !== exp || b_voice_stolen !== 1'b1) begin n_bad++; $display("FAIL b2b_steal%0d: got %b/%b want %b/1", i, b_load_voice, b_voice_stolen, exp); end
      n_cmp++; if (a_note_dropped !== 1'b1) begin n_bad++; $display("FAIL b2b_drop%0d: got %b want 1", i, a_note_dropped); end
    end
    note_in = 6'd55; tick; note_valid = 1'b0;
    n_cmp++; if (b_load_voice !== 4'b0010) begin n_bad++; $display("FAIL steal_wrap: got %b want 0010", b_load_voice); end
    tick;
    n_cmp++; if (b_voice_stolen !== 1'b0 || b_note_out[0 +: 6] !== 6'd54) begin n_bad++; $display("FAIL steal_end: got %b/%0d want 0/54", b_voice_stolen, b_note_out[0 +: 6]); end
  endtask

  task automatic test_load_done;
    voice_done = 4'b0001; tick; voice_done = 4'b0000;
    n_cmp++; if (b_busy !== 4'b1110) begin n_bad++; $display("FAIL ld_free: got %b want 1110", b_busy); end
    note_valid = 1'b1; note_in = 6'd60; voice_done = 4'b0001; tick;
    note_valid = 1'b0; voice_done = 4'b0000;
    n_cmp++; if (b_load_voice !== 4'b0001 || b_voice_stolen !== 1'b0) begin n_bad++; $display("FAIL ld_load: got %b/%b want 0001/0", b_load_voice, b_voice_stolen); end
    n_cmp++; if (b_busy !== 4'b1111 || a_busy !== 4'b1111) begin n_bad++; $display("FAIL ld_busy: got %b/%b want 1111/1111", b_busy, a_busy); end
  endtask

  task automatic test_mix;
    samples_in = SAMP_A; voice_mute = 4'b0000; mix_start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick; mix_start = 1'b0;
      n_cmp++; if (a_mix_valid !== (c == 6)) begin n_bad++; $display("FAIL mix_lat_c%0d: got %b want %b", c, a_mix_valid, (c == 6)); end
      if (c == 6) begin
        n_cmp++; if (a_mix_out !== 16'h0A00 || a_clip !== 1'b0) begin n_bad++; $display("FAIL mix_a: got %h/%b want 0a00/0", a_mix_out, a_clip); end
        n_cmp++; if (b_mix_out !== 16'h2800 || b_clip !== 1'b0) begin n_bad++; $display("FAIL mix_b: got %h/%b want 2800/0", b_mix_out, b_clip); end
      end
    end
    n_cmp++; if (a_mix_out !== 16'h0A00) begin n_bad++; $display("FAIL mix_hold: got %h want 0a00", a_mix_out); end
  endtask

  task automatic test_mute;
    int lat;
    do_mix(SAMP_A, 4'b0010, lat);
    n_cmp++; if (lat != 6) begin n_bad++; $display("FAIL mute_lat: got %0d want 6", lat); end
    n_cmp++; if (a_mix_out !== 16'h0200 || b_mix_out !== 16'h0800) begin n_bad++; $display("FAIL mute_out: got %h/%h want 0200/0800", a_mix_out, b_mix_out); end
    voice_mute = 4'b0000; tick;
  endtask

  task automatic test_clip;
    int lat;
    do_mix({4{16'h7000}}, 4'b0000, lat);
    n_cmp++; if (lat != 6) begin n_bad++; $display("FAIL clip_pos_lat: got %0d want 6", lat); end
    n_cmp++; if (b_mix_out !== 16'h7FFF || b_clip !== 1'b1) begin n_bad++; $display("FAIL clip_pos_b: got %h/%b want 7fff/1", b_mix_out, b_clip); end
    n_cmp++; if (a_mix_out !== 16'h7000 || a_clip !== 1'b0) begin n_bad++; $display("FAIL edge_pos_a: got %h/%b want 7000/0", a_mix_out, a_clip); end
    tick;
    do_mix({4{16'h8000}}, 4'b0000, lat);
    n_cmp++; if (b_mix_out !== 16'h8000 || b_clip !== 1'b1) begin n_bad++; $display("FAIL clip_neg_b: got %h/%b want 8000/1", b_mix_out, b_clip); end
    n_cmp++; if (a_mix_out !== 16'h8000 || a_clip !== 1'b0) begin n_bad++; $display("FAIL edge_neg_a: got %h/%b want 8000/0", a_mix_out, a_clip); end
    tick;
  endtask

  task automatic test_overrun;
    int  cnt = 0;
    logic v6 = 1'b0, ov4 = 1'b1;
    samples_in = SAMP_A; mix_start = 1'b1; tick; mix_start = 1'b0;
    n_cmp++; if (a_mix_overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_early: got %b want 0", a_mix_overrun); end
    tick; mix_start = 1'b1; tick; mix_start = 1'b0;
    n_cmp++; if (a_mix_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_pulse: got %b want 1", a_mix_overrun); end
    for (int c = 4; c <= 11; c++) begin
      tick;
      if (a_mix_valid) cnt++;
      if (c == 4) ov4 = a_mix_overrun;
      if (c == 6) v6 = a_mix_valid;
    end
    n_cmp++; if (cnt != 1 || v6 !== 1'b1) begin n_bad++; $display("FAIL ovr_valid: got cnt=%0d at6=%b want 1/1", cnt, v6); end
    n_cmp++; if (ov4 !== 1'b0) begin n_bad++; $display("FAIL ovr_width: got %b want 0", ov4); end
    n_cmp++; if (a_mix_out !== 16'h0A00) begin n_bad++; $display("FAIL ovr_out: got %h want 0a00", a_mix_out); end
  endtask

  task automatic test_reset_mid_mix;
    int cnt = 0;
    samples_in = {4{16'h7000}}; mix_start = 1'b1; tick; mix_start = 1'b0;
    tick; tick;
    reset = 1'b1; tick;
    n_cmp++; if (a_mix_valid !== 1'b0 || a_mix_out !== 16'h0 || b_mix_out !== 16'h0) begin n_bad++; $display("FAIL rst_mid: got %b/%h/%h want 0/0/0", a_mix_valid, a_mix_out, b_mix_out); end
    n_cmp++; if (a_busy !== 4'b0000) begin n_bad++; $display("FAIL rst_busy: got %b want 0000", a_busy); end
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin tick; if (a_mix_valid || b_mix_valid) cnt++; end
    n_cmp++; if (cnt != 0 || a_mix_out !== 16'h0 || b_clip !== 1'b0) begin n_bad++; $display("FAIL rst_after: got cnt=%0d out=%h clip=%b want 0/0/0", cnt, a_mix_out, b_clip); end
  endtask

  initial begin
    reset = 1'b1; note_valid = 1'b0; mix_start = 1'b0; note_in = '0; duration_in = '0;
    voice_done = '0; voice_mute = '0; samples_in = '0;
    test_reset;
    test_alloc;
    test_drop;
    test_back_to_back;
    test_load_done;
    test_mix;
    test_mute;
    test_clip;
    test_overrun;
    test_reset_mid_mix;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
